// File: rtl/io_out_uart.sv
// io_out_uart: buffers 16-bit CPU output words in a FIFO and sends each one
// as two 8N1 UART bytes, low byte first, on a registered tx line.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | line idle (tx=1); pops the head word as soon as the FIFO is non-empty
// START | start bit (tx=0) for CLKS_PER_BIT cycles
// DATA  | 8 data bits of the selected byte, LSB first
// STOP  | stop bit (tx=1); goes back to START for the high byte, else to IDLE
module io_out_uart #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [15:0]                   wr_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          busy,
  output logic                          overflow,
  output logic                          tx
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [15:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q;
  logic          overflow_q;
  logic          push, pop;

  state_t        state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0]    bit_idx, bit_n;
  logic          byte_sel, sel_n;
  logic [15:0]   word_q, word_n;
  logic          tx_q, tx_n;
  logic [7:0]    cur_byte;
  logic          baud_tc;

  // Full/empty come straight from the registered occupancy, so a write
  // into an empty FIFO is only poppable on the following cycle.
  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign overflow = overflow_q;
  assign busy     = (state != IDLE);
  assign tx       = tx_q;

  // A write while full is dropped even if the FSM pops in the same cycle.
  assign push = wr_en && !full;

  // Storage array; no reset needed because occupancy guards every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // FIFO pointers, exact occupancy count and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (wr_en && full) overflow_q <= 1'b1;
    end
  end

  assign cur_byte = byte_sel ? word_q[15:8] : word_q[7:0];
  assign baud_tc  = (baud == BW'(CLKS_PER_BIT - 1));

  // Transmitter state register; tx is registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud     <= '0;
      bit_idx  <= '0;
      byte_sel <= 1'b0;
      word_q   <= '0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_n;
      baud     <= baud_n;
      bit_idx  <= bit_n;
      byte_sel <= sel_n;
      word_q   <= word_n;
      tx_q     <= tx_n;
    end
  end

  // Next-state logic; tx_n is the line level for the cycle being entered.
  always_comb begin
    state_n = state;
    baud_n  = baud;
    bit_n   = bit_idx;
    sel_n   = byte_sel;
    word_n  = word_q;
    tx_n    = tx_q;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          word_n  = mem[rd_ptr];
          sel_n   = 1'b0;
          baud_n  = '0;
          state_n = START;
          tx_n    = 1'b0;
        end
      end
      START: begin
        if (baud_tc) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = DATA;
          tx_n    = cur_byte[0];
        end else begin
          baud_n  = baud + BW'(1);
        end
      end
      DATA: begin
        if (baud_tc) begin
          baud_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            bit_n = bit_idx + 3'd1;
            tx_n  = cur_byte[bit_idx + 3'd1];
          end
        end else begin
          baud_n = baud + BW'(1);
        end
      end
      STOP: begin
        if (baud_tc) begin
          baud_n = '0;
          if (!byte_sel) begin
            sel_n   = 1'b1;
            state_n = START;
            tx_n    = 1'b0;
          end else begin
            state_n = IDLE;
            tx_n    = 1'b1;
          end
        end else begin
          baud_n = baud + BW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_io_out_uart.sv
// Bench for io_out_uart: directed timing checks, an expected-word queue and a
// behavioural UART receiver that decodes tx independently of the design.
module tb_io_out_uart;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;

  logic        clk, rst, wr_en;
  logic [15:0] wr_data;
  logic        full, empty, busy, overflow, tx;
  logic [3:0]  count;

  int vectors    = 0;
  int miscompares = 0;

  logic [15:0] exp_q[$];
  int          rx_words = 0;

  io_out_uart #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .busy(busy),
    .overflow(overflow), .tx(tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Line level expected at bit slot idx (0..19) of a two-byte 8N1 word frame.
  function automatic logic exp_bit(input logic [15:0] w, input int idx);
    logic [7:0] b;
    int p;
    b = (idx < 10) ? w[7:0] : w[15:8];
    p = idx % 10;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return b[p-1];
  endfunction

  // Receiver: samples mid-bit, assembles low/high bytes into words.
  logic       in_frame = 1'b0, have_low = 1'b0;
  int         cyc = 0;
  logic [7:0] sh, lo;
  always @(negedge clk) begin
    if (rst) begin
      in_frame = 1'b0;
      have_low = 1'b0;
    end else if (!in_frame) begin
      if (tx === 1'b0) begin
        in_frame = 1'b1;
        cyc = 0;
      end
    end else begin
      cyc++;
      if (cyc >= CPB/2 && ((cyc - CPB/2) % CPB) == 0) begin
        int k;
        k = (cyc - CPB/2) / CPB;
        if (k == 0) chk("rx_start", tx, 1'b0);
        else if (k <= 8) sh[k-1] = tx;
        else begin
          chk("rx_stop", tx, 1'b1);
          in_frame = 1'b0;
          if (!have_low) begin
            lo = sh;
            have_low = 1'b1;
          end else begin
            have_low = 1'b0;
            rx_words++;
            if (exp_q.size() == 0) chk("rx_unexpected", {sh, lo}, 32'hFFFF_FFFF);
            else chk("rx_word", {sh, lo}, exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic reset_dut();
    rst = 1'b1;
    wr_en = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_full", full, 1'b0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_count", count, 0);
    chk("rst_overflow", overflow, 1'b0);
  endtask

  task automatic check_frame(input string tag, input logic [15:0] w);
    for (int i = 0; i < 20*CPB; i++) begin
      chk(tag, tx, exp_bit(w, i / CPB));
      if (i % CPB == 0) chk({tag, "_busy"}, busy, 1'b1);
      tick();
    end
  endtask

  task automatic wait_drain(input string tag, input int max);
    int n = 0;
    while ((busy !== 1'b0 || empty !== 1'b1) && n < max) begin
      tick();
      n++;
    end
    chk({tag, "_timeout"}, (n < max), 1'b1);
    tick();
    chk({tag, "_rxq"}, exp_q.size(), 0);
  endtask

  initial begin
    logic [15:0] w, w1;
    int n, rx0;
    rst = 1'b1;
    wr_en = 1'b0;
    wr_data = '0;
    reset_dut();

    // 1: single word 0x12A5, exact line timing
    wr_data = 16'h12A5; wr_en = 1'b1; exp_q.push_back(16'h12A5);
    tick();
    wr_en = 1'b0; wr_data = 16'($urandom);
    chk("t1_empty_n1", empty, 1'b0);
    chk("t1_count_n1", count, 1);
    chk("t1_tx_n1", tx, 1'b1);
    chk("t1_busy_n1", busy, 1'b0);
    tick();
    chk("t1_tx_n2", tx, 1'b0);
    chk("t1_busy_n2", busy, 1'b1);
    chk("t1_empty_n2", empty, 1'b1);
    check_frame("t1_frame", 16'h12A5);
    chk("t1_idle_busy", busy, 1'b0);
    chk("t1_idle_tx", tx, 1'b1);
    wait_drain("t1", 50);

    // 2: ten back-to-back writes, the tenth overflows
    reset_dut();
    wr_en = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      wr_data = 16'(i);
      if (i <= 9) exp_q.push_back(16'(i));
      tick();
      if (i == 9) begin
        chk("t2_full9", full, 1'b1);
        chk("t2_count9", count, 8);
        chk("t2_ovf9", overflow, 1'b0);
      end
    end
    wr_en = 1'b0; wr_data = 16'($urandom);
    chk("t2_ovf10", overflow, 1'b1);
    chk("t2_count10", count, 8);
    wait_drain("t2", 1500);
    chk("t2_ovf_sticky", overflow, 1'b1);

    // 3: write while full coinciding with a pop
    reset_dut();
    wr_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      w = 16'($urandom);
      wr_data = w;
      exp_q.push_back(w);
      tick();
    end
    wr_en = 1'b0;
    chk("t3_full", full, 1'b1);
    chk("t3_ovf_pre", overflow, 1'b0);
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    chk("t3_wait_idle", (n < 200), 1'b1);
    wr_data = 16'hDEAD; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    chk("t3_ovf", overflow, 1'b1);
    chk("t3_count7", count, 7);
    chk("t3_busy", busy, 1'b1);
    wait_drain("t3", 1500);

    // 4: inter-word gap is exactly one idle cycle
    reset_dut();
    wr_data = 16'hFF00; wr_en = 1'b1; exp_q.push_back(16'hFF00);
    tick();
    wr_data = 16'h00FF; exp_q.push_back(16'h00FF);
    tick();
    wr_en = 1'b0;
    check_frame("t4_frame_a", 16'hFF00);
    chk("t4_gap_tx", tx, 1'b1);
    chk("t4_gap_busy", busy, 1'b0);
    chk("t4_gap_count", count, 1);
    tick();
    chk("t4_start_tx", tx, 1'b0);
    check_frame("t4_frame_b", 16'h00FF);
    chk("t4_end_busy", busy, 1'b0);
    wait_drain("t4", 50);

    // 5: reset during high-byte data with three words queued
    reset_dut();
    w1 = 16'($urandom);
    wr_data = w1; wr_en = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      wr_data = 16'($urandom);
      tick();
    end
    wr_en = 1'b0;
    chk("t5_count3", count, 3);
    repeat (12*CPB + 1 - 2) tick();
    chk("t5_high_data", tx, exp_bit(w1, 12));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    chk("t5_tx", tx, 1'b1);
    chk("t5_busy", busy, 1'b0);
    chk("t5_count", count, 0);
    chk("t5_empty", empty, 1'b1);
    chk("t5_ovf", overflow, 1'b0);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (tx !== 1'b1 || busy !== 1'b0) n++;
      tick();
    end
    chk("t5_quiet", n, 0);
    w = 16'($urandom);
    wr_data = w; wr_en = 1'b1; exp_q.push_back(w);
    tick();
    wr_en = 1'b0;
    wait_drain("t5", 200);

    // 6: 20 spaced random words, pointers wrap
    reset_dut();
    rx0 = rx_words;
    for (int i = 0; i < 20; i++) begin
      w = 16'($urandom);
      wr_data = w; wr_en = 1'b1; exp_q.push_back(w);
      tick();
      wr_en = 1'b0; wr_data = 16'($urandom);
      chk("t6_empty_n1", empty, 1'b0);
      tick();
      chk("t6_tx_n2", tx, 1'b0);
      chk("t6_busy_n2", busy, 1'b1);
      repeat (25*CPB - 2) tick();
    end
    wait_drain("t6", 200);
    chk("t6_ovf", overflow, 1'b0);
    chk("t6_rx_words", rx_words - rx0, 20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
